// File: rtl/pipelined_cla_adder_pkg.sv
// Shared helpers for segmented/pipelined carry-lookahead arithmetic.
// Used by pipelined_cla_adder and intended for future pipelined MAC blocks.
// Optional feature macro used by the adder: PIPE_ADD_OVF_EN.
package pipelined_cla_adder_pkg;

    localparam int DEFAULT_N   = 33;
    localparam int DEFAULT_SEG = 8;

    // Number of SEG-bit segments (pipeline stages) needed to cover n bits.
    function automatic int cla_num_stages(int n, int seg);
        return (n + seg - 1) / seg;
    endfunction

    // Lowest bit index covered by segment k.
    function automatic int cla_seg_lo(int k, int seg);
        return k * seg;
    endfunction

    // Width of segment k; only the last segment may be narrower than seg.
    function automatic int cla_seg_width(int k, int n, int seg);
        int stages;
        stages = cla_num_stages(n, seg);
        return (k == stages - 1) ? (n - (stages - 1) * seg) : seg;
    endfunction

    // Offset of skew register k (holds operand bits [n-1:k*seg]) in the packed skew vector.
    function automatic int cla_skew_off(int k, int n, int seg);
        int acc;
        acc = 0;
        for (int j = 1; j < k; j++) begin
            acc = acc + (n - j * seg);
        end
        return acc;
    endfunction

    // Offset of deskew register k (holds result bits [k*seg-1:0]) in the packed deskew vector.
    function automatic int cla_lo_off(int k, int seg);
        return (seg * k * (k - 1)) / 2;
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Valid/ready operand and result bus of the pipelined CLA adder.
// The ovf wire exists only when PIPE_ADD_OVF_EN is defined.
interface pipelined_cla_adder_if #(
    parameter int N = 33
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] SUM;
    logic         cout;
`ifdef PIPE_ADD_OVF_EN
    logic         ovf;

    modport master (output in_valid, A, B, cin, out_ready,
                    input  in_ready, out_valid, SUM, cout, ovf);
    modport slave  (input  in_valid, A, B, cin, out_ready,
                    output in_ready, out_valid, SUM, cout, ovf);
`else
    modport master (output in_valid, A, B, cin, out_ready,
                    input  in_ready, out_valid, SUM, cout);
    modport slave  (input  in_valid, A, B, cin, out_ready,
                    output in_ready, out_valid, SUM, cout);
`endif
endinterface

// File: rtl/pipelined_cla_adder_stage.sv
// One registered W-bit carry-lookahead segment of the pipelined adder.
// Carries are formed as flat generate/propagate sums of products so the
// segment delay does not ripple through W full adders.
module pipelined_cla_stage
    import pipelined_cla_adder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         carry_in,
    input  logic         valid_in,
    output logic [W-1:0] sum,
    output logic         carry_out,
    output logic         valid_out
);
    logic [W-1:0] g_s;
    logic [W-1:0] p_s;
    logic [W:0]   c_s;

    // Lookahead carries: c[i+1] = OR_j (g[j] & p[j+1..i]) | (p[0..i] & carry_in).
    always_comb begin
        logic term_s;
        logic prod_s;
        term_s = 1'b0;
        prod_s = 1'b1;
        g_s    = a & b;
        p_s    = a ^ b;
        c_s    = '0;
        c_s[0] = carry_in;
        for (int i = 0; i < W; i++) begin
            term_s = 1'b0;
            prod_s = 1'b1;
            for (int j = i; j >= 0; j--) begin
                term_s = term_s | (prod_s & g_s[j]);
                prod_s = prod_s & p_s[j];
            end
            c_s[i+1] = term_s | (prod_s & carry_in);
        end
    end

    // Segment result, carry and valid registers; frozen while the pipe is stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum       <= '0;
            carry_out <= 1'b0;
            valid_out <= 1'b0;
        end else if (en) begin
            sum       <= p_s ^ c_s[W-1:0];
            carry_out <= c_s[W];
            valid_out <= valid_in;
        end
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined N-bit carry-lookahead adder with valid/ready flow control.
// Stage k adds operand segment k plus the registered carry of stage k-1.
// Upper operand segments wait in skew registers, finished lower result
// segments wait in deskew registers, so a whole sum emerges at once.
// Define PIPE_ADD_OVF_EN to build the signed-overflow output.
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int N   = DEFAULT_N,
    parameter int SEG = DEFAULT_SEG
) (
    input logic                  clk,
    input logic                  reset_n,
    pipelined_cla_adder_if.slave bus
);
    localparam int STAGES  = cla_num_stages(N, SEG);
    localparam int LAST_LO = cla_seg_lo(STAGES - 1, SEG);
    localparam int LAST_W  = N - LAST_LO;

    logic              adv;
    logic [N-1:0]      op_a;
    logic [N-1:0]      op_b;
    logic [N-1:0]      stage_sum;
    logic [STAGES-1:0] stage_c;
    logic [STAGES-1:0] stage_v;

    // The whole pipe moves only when the output slot is empty or being consumed.
    assign adv           = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready  = adv;
    assign bus.out_valid = stage_v[STAGES-1];
    assign bus.cout      = stage_c[STAGES-1];

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            localparam int LO = cla_seg_lo(k, SEG);
            localparam int W  = cla_seg_width(k, N, SEG);
            logic c_in;
            logic v_in;
            if (k == 0) begin : g_first
                assign c_in = bus.cin;
                assign v_in = bus.in_valid;
            end else begin : g_next
                assign c_in = stage_c[k-1];
                assign v_in = stage_v[k-1];
            end
            pipelined_cla_stage #(.W(W)) u_stage (
                .clk       (clk),
                .reset_n   (reset_n),
                .en        (adv),
                .a         (op_a[LO +: W]),
                .b         (op_b[LO +: W]),
                .carry_in  (c_in),
                .valid_in  (v_in),
                .sum       (stage_sum[LO +: W]),
                .carry_out (stage_c[k]),
                .valid_out (stage_v[k])
            );
        end

        if (STAGES == 1) begin : g_single
            assign op_a    = bus.A;
            assign op_b    = bus.B;
            assign bus.SUM = stage_sum;
        end else begin : g_multi
            localparam int SKW = cla_skew_off(STAGES, N, SEG);
            localparam int LOW = cla_lo_off(STAGES, SEG);
            logic [SKW-1:0] skew_a_r;
            logic [SKW-1:0] skew_b_r;
            logic [LOW-1:0] lo_r;

            assign op_a[SEG-1:0] = bus.A[SEG-1:0];
            assign op_b[SEG-1:0] = bus.B[SEG-1:0];
            assign bus.SUM = {stage_sum[LAST_LO +: LAST_W],
                              lo_r[cla_lo_off(STAGES - 1, SEG) +: LAST_LO]};

            for (k = 1; k < STAGES; k++) begin : g_skew
                localparam int SO = cla_skew_off(k, N, SEG);
                localparam int SW = N - k * SEG;
                localparam int W  = cla_seg_width(k, N, SEG);
                localparam int LO = cla_lo_off(k, SEG);
                logic [SW-1:0]    src_a_s;
                logic [SW-1:0]    src_b_s;
                logic [k*SEG-1:0] src_lo_s;

                assign op_a[k*SEG +: W] = skew_a_r[SO +: W];
                assign op_b[k*SEG +: W] = skew_b_r[SO +: W];

                if (k == 1) begin : g_src_in
                    assign src_a_s  = bus.A[N-1:SEG];
                    assign src_b_s  = bus.B[N-1:SEG];
                    assign src_lo_s = stage_sum[SEG-1:0];
                end else begin : g_src_chain
                    assign src_a_s  = skew_a_r[cla_skew_off(k - 1, N, SEG) + SEG +: SW];
                    assign src_b_s  = skew_b_r[cla_skew_off(k - 1, N, SEG) + SEG +: SW];
                    assign src_lo_s = {stage_sum[(k-1)*SEG +: SEG],
                                       lo_r[cla_lo_off(k - 1, SEG) +: (k-1)*SEG]};
                end

                // Skew (pending operand bits) and deskew (finished low sum bits) for boundary k.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        skew_a_r[SO +: SW]  <= '0;
                        skew_b_r[SO +: SW]  <= '0;
                        lo_r[LO +: k*SEG]   <= '0;
                    end else if (adv) begin
                        skew_a_r[SO +: SW]  <= src_a_s;
                        skew_b_r[SO +: SW]  <= src_b_s;
                        lo_r[LO +: k*SEG]   <= src_lo_s;
                    end
                end
            end
        end
    endgenerate

`ifdef PIPE_ADD_OVF_EN
    logic sign_a_r;
    logic sign_b_r;

    // Operand sign bits follow the op into the final stage alongside the top segment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
        end else if (adv) begin
            sign_a_r <= op_a[N-1];
            sign_b_r <= op_b[N-1];
        end
    end

    assign bus.ovf = (sign_a_r == sign_b_r) & (bus.SUM[N-1] != sign_a_r);
`else
    // Without the overflow option no sign-bit pipeline is built.
`endif

endmodule
